audio_tx_dma_seq: RTL and testbench

Read-DMA sequencer for the audio transmit path. It fetches sample words from external memory over the Ufi master port in bursts, throttled by free space in the downstream dual-clock sample FIFO. It pushes the returned words into that FIFO. It sits between the audio CSR (base address, length, enable, loop) and the Ufi bus, all in the system clock domain.

---
 rtl/audio_dma_pkg.sv | 16 +
 rtl/audio_tx_dma_seq.sv | 158 +++++++++++++++
 tb/tb_audio_tx_dma_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dma_pkg.sv
// audio_dma_pkg
//   Shared definitions for the audio transmit read-DMA sequencer:
//   the 3-bit sequencer state encoding and the default burst length.
package audio_dma_pkg;

    typedef enum logic [2:0] {
        stIdle      = 3'd0,
        stWaitSpace = 3'd1,
        stIssue     = 3'd2,
        stDrain     = 3'd3,
        stHold      = 3'd4
    } dmaState_e;

    localparam int cDefBurstLen = 16;

endpackage

// File: rtl/audio_tx_dma_seq.sv
// audio_tx_dma_seq
//   Read-DMA sequencer for the audio transmit path. Fetches sample words over
//   the Ufi master port in bursts sized to the free space of the sample FIFO
//   and pushes the returned words into that FIFO.
// Ports
//   iSysClk, iSysRst          clock, synchronous active-high reset
//   iDmaAdrs/Len/En/Loop      CSR: start word address, length, enable, loop
//   iFifoFree                 free entries in the downstream sample FIFO
//   oMUfiAdrs/REd/WEd/Vd      Ufi request (decoded from state, no input path)
//   iMUfiRdy                  Ufi request accepted this cycle
//   iMUfiRd/iMUfiREd          Ufi read data / read data valid
//   oFifoWd/oFifoWe           sample FIFO write
//   oDmaBusy, oDmaDone        status: busy level, end-of-buffer pulse
module audio_tx_dma_seq
    import audio_dma_pkg::*;
#(
    parameter int pBusAdrsBit   = 32,
    parameter int pUfiBusWidth  = 16,
    parameter int pMemAdrsWidth = 19,
    parameter int pBurstLen     = cDefBurstLen,
    parameter int pFifoCntWidth = 11
) (
    input  logic                     iSysClk,
    input  logic                     iSysRst,
    input  logic [pMemAdrsWidth-1:0] iDmaAdrs,
    input  logic [pMemAdrsWidth-1:0] iDmaLen,
    input  logic                     iDmaEn,
    input  logic                     iDmaLoop,
    input  logic [pFifoCntWidth-1:0] iFifoFree,
    output logic [pBusAdrsBit-1:0]   oMUfiAdrs,
    output logic                     oMUfiREd,
    output logic                     oMUfiWEd,
    output logic                     oMUfiVd,
    input  logic                     iMUfiRdy,
    input  logic [pUfiBusWidth-1:0]  iMUfiRd,
    input  logic                     iMUfiREd,
    output logic [pUfiBusWidth-1:0]  oFifoWd,
    output logic                     oFifoWe,
    output logic                     oDmaBusy,
    output logic                     oDmaDone
);

    localparam int cOutW = $clog2(pBurstLen) + 1;

    dmaState_e                state, stateNext;
    logic [pMemAdrsWidth-1:0] curAdrs, remain, issued;
    logic [cOutW-1:0]         outstanding, burst, burstCur;
    logic                     accept, retOk, startLatch, reload, doneNext;

    assign accept = (state == stIssue) && iMUfiRdy;
    // Returns with nothing in flight (e.g. after a reset) are discarded.
    assign retOk  = iMUfiREd && (outstanding != '0);

    // Request side decodes purely from registered state.
    assign oMUfiVd   = (state == stIssue);
    assign oMUfiREd  = (state == stIssue);
    assign oMUfiWEd  = 1'b0;
    assign oMUfiAdrs = (state == stIssue) ? pBusAdrsBit'(curAdrs) : '0;

    assign burstCur = (remain >= pMemAdrsWidth'(pBurstLen)) ? cOutW'(pBurstLen)
                                                            : cOutW'(remain);

    always_comb begin
        stateNext  = state;
        doneNext   = 1'b0;
        startLatch = 1'b0;
        reload     = 1'b0;
        case (state)
            stIdle: begin
                if (iDmaEn) begin
                    if (iDmaLen == '0) begin
                        doneNext  = 1'b1;
                        stateNext = stHold;
                    end else begin
                        startLatch = 1'b1;
                        stateNext  = stWaitSpace;
                    end
                end
            end
            stWaitSpace: begin
                if (!iDmaEn)
                    stateNext = stIdle;
                else if (32'(iFifoFree) >= 32'(burstCur))
                    stateNext = stIssue;
            end
            stIssue: begin
                // Disable still lets the beat of this cycle complete.
                if (!iDmaEn || (accept && ((issued + 1'b1) == pMemAdrsWidth'(burst))))
                    stateNext = stDrain;
            end
            stDrain: begin
                if (outstanding == '0) begin
                    if (!iDmaEn)
                        stateNext = stIdle;
                    else if (remain == '0) begin
                        doneNext = 1'b1;
                        // A zero-length reload would issue nothing; park instead.
                        if (iDmaLoop && (iDmaLen != '0)) begin
                            reload    = 1'b1;
                            stateNext = stWaitSpace;
                        end else
                            stateNext = stHold;
                    end else
                        stateNext = stWaitSpace;
                end
            end
            stHold: begin
                if (!iDmaEn)
                    stateNext = stIdle;
            end
            default: stateNext = stIdle;
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state       <= stIdle;
            curAdrs     <= '0;
            remain      <= '0;
            issued      <= '0;
            burst       <= '0;
            outstanding <= '0;
            oFifoWd     <= '0;
            oFifoWe     <= 1'b0;
            oDmaBusy    <= 1'b0;
            oDmaDone    <= 1'b0;
        end else begin
            state    <= stateNext;
            oDmaDone <= doneNext;
            oDmaBusy <= (stateNext != stIdle) && (stateNext != stHold);

            if (startLatch || reload) begin
                curAdrs <= iDmaAdrs;
                remain  <= iDmaLen;
            end else if (accept) begin
                curAdrs <= curAdrs + 1'b1;
                remain  <= remain - 1'b1;
            end

            if ((state == stWaitSpace) && (stateNext == stIssue)) begin
                burst  <= burstCur;
                issued <= '0;
            end else if (accept)
                issued <= issued + 1'b1;

            case ({accept, retOk})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            oFifoWe <= retOk;
            if (retOk)
                oFifoWd <= iMUfiRd;
        end
    end

endmodule

// File: tb/tb_audio_tx_dma_seq.sv
// tb_audio_tx_dma_seq
//   Directed bench for audio_tx_dma_seq: a table of complete transfers plus
//   hand-written sequences for start latency, FIFO throttling, loop wrap,
//   disable mid-burst, zero length and reset with reads in flight.
//   A negedge process acts as a fixed 3-cycle-latency memory and records
//   accepted addresses, FIFO writes and done pulses.
module tb_audio_tx_dma_seq;

    logic        iSysClk = 1'b0;
    logic        iSysRst;
    logic [18:0] iDmaAdrs, iDmaLen;
    logic        iDmaEn, iDmaLoop;
    logic [10:0] iFifoFree;
    logic [31:0] oMUfiAdrs;
    logic        oMUfiREd, oMUfiWEd, oMUfiVd;
    logic        iMUfiRdy;
    logic [15:0] iMUfiRd;
    logic        iMUfiREd;
    logic [15:0] oFifoWd;
    logic        oFifoWe, oDmaBusy, oDmaDone;

    audio_tx_dma_seq dut (
        .iSysClk(iSysClk), .iSysRst(iSysRst),
        .iDmaAdrs(iDmaAdrs), .iDmaLen(iDmaLen), .iDmaEn(iDmaEn), .iDmaLoop(iDmaLoop),
        .iFifoFree(iFifoFree),
        .oMUfiAdrs(oMUfiAdrs), .oMUfiREd(oMUfiREd), .oMUfiWEd(oMUfiWEd), .oMUfiVd(oMUfiVd),
        .iMUfiRdy(iMUfiRdy), .iMUfiRd(iMUfiRd), .iMUfiREd(iMUfiREd),
        .oFifoWd(oFifoWd), .oFifoWe(oFifoWe), .oDmaBusy(oDmaBusy), .oDmaDone(oDmaDone)
    );

    always #5 iSysClk = ~iSysClk;

    int nCmp = 0, nFail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memData(input logic [18:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // memory model / monitor state
    int          rdyMode = 0;      // 0: always ready, 1: toggle, 2: driven by main
    int          negCyc = 0, lastWe = -100;
    bit          chkGap = 1'b1;
    logic [18:0] adrsQ[$];
    logic [15:0] fifoQ[$];
    int          retDue[$];
    logic [15:0] retDat[$];
    int          doneCnt = 0, bursts = 0, curRun = 0, maxRun = 0, holdErr = 0, vdCyc = 0;
    logic        prevVd = 1'b0, prevRdy = 1'b0;
    logic [31:0] prevAdrs = '0;

    initial begin
        iMUfiREd = 1'b0;
        iMUfiRd  = '0;
        forever begin
            @(negedge iSysClk);
            negCyc++;
            if (rdyMode == 1)      iMUfiRdy = ~iMUfiRdy;
            else if (rdyMode == 0) iMUfiRdy = 1'b1;
            if (prevVd && !prevRdy && oMUfiVd && (oMUfiAdrs !== prevAdrs)) holdErr++;
            if (oMUfiVd && !prevVd) begin bursts++; curRun = 0; end
            if (oMUfiVd) vdCyc++;
            // read data for the next edge
            iMUfiREd = 1'b0;
            if (retDue.size() > 0 && retDue[0] == negCyc) begin
                iMUfiREd = 1'b1;
                iMUfiRd  = retDat[0];
                void'(retDue.pop_front());
                void'(retDat.pop_front());
            end
            // beat accepted at the coming edge, sampled back 3 edges later
            if (oMUfiVd && iMUfiRdy) begin
                adrsQ.push_back(oMUfiAdrs[18:0]);
                retDue.push_back(negCyc + 3);
                retDat.push_back(memData(oMUfiAdrs[18:0]));
                curRun++;
                if (curRun > maxRun) maxRun = curRun;
            end
            if (oFifoWe) begin fifoQ.push_back(oFifoWd); lastWe = negCyc; end
            if (oDmaDone) begin
                doneCnt++;
                if (chkGap) cmp("doneAfterLastWrite", negCyc - lastWe, 1);
            end
            prevVd = oMUfiVd; prevRdy = iMUfiRdy; prevAdrs = oMUfiAdrs;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iSysClk);
        #2;
    endtask

    task automatic clearMon();
        adrsQ.delete(); fifoQ.delete();
        doneCnt = 0; bursts = 0; curRun = 0; maxRun = 0; holdErr = 0; vdCyc = 0;
        lastWe = -100;
    endtask

    typedef struct {
        logic [18:0] adrs;
        logic [18:0] len;
        bit          tog;
        int          expBursts;
        int          expMax;
        int          expLast;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [18:0] ea;
        vecs[0] = '{19'h00100, 19'd40, 1'b0, 3, 16, 8};
        vecs[1] = '{19'h00200, 19'd5,  1'b1, 1, 5,  5};
        vecs[2] = '{19'h03000, 19'd17, 1'b0, 2, 16, 1};
        vecs[3] = '{19'h00010, 19'd1,  1'b0, 1, 1,  1};

        iSysRst = 1'b1; iDmaAdrs = '0; iDmaLen = '0; iDmaEn = 1'b0; iDmaLoop = 1'b0;
        iFifoFree = 11'd1023; iMUfiRdy = 1'b1;
        repeat (3) tick();
        cmp("rstVd", oMUfiVd, 0);
        cmp("rstREd", oMUfiREd, 0);
        cmp("rstWEd", oMUfiWEd, 0);
        cmp("rstAdrs", oMUfiAdrs, 0);
        cmp("rstFifoWe", oFifoWe, 0);
        cmp("rstFifoWd", oFifoWd, 0);
        cmp("rstBusy", oDmaBusy, 0);
        cmp("rstDone", oDmaDone, 0);
        iSysRst = 1'b0;
        tick();

        // table of complete transfers
        for (int v = 0; v < 4; v++) begin
            clearMon();
            chkGap = 1'b1;
            rdyMode = vecs[v].tog ? 1 : 0;
            iDmaAdrs = vecs[v].adrs; iDmaLen = vecs[v].len; iDmaEn = 1'b1;
            for (int c = 0; c < 600 && doneCnt == 0; c++) tick();
            repeat (5) tick();
            cmp("vecBeats", adrsQ.size(), vecs[v].len);
            cmp("vecWrites", fifoQ.size(), vecs[v].len);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                ea = vecs[v].adrs + 19'(i);
                if (i < adrsQ.size()) cmp("vecAdrs", adrsQ[i], ea);
                if (i < fifoQ.size()) cmp("vecData", fifoQ[i], memData(ea));
            end
            cmp("vecBursts", bursts, vecs[v].expBursts);
            cmp("vecMaxBurst", maxRun, vecs[v].expMax);
            cmp("vecLastBurst", curRun, vecs[v].expLast);
            cmp("vecDone", doneCnt, 1);
            cmp("vecHoldBusy", oDmaBusy, 0);
            cmp("vecAdrsHeld", holdErr, 0);
            iDmaEn = 1'b0;
            rdyMode = 0;
            repeat (3) tick();
        end

        // FIFO throttling: 10 free < burst 16, then 16 free
        clearMon();
        iDmaAdrs = 19'h00800; iDmaLen = 19'd40; iFifoFree = 11'd10; iDmaEn = 1'b1;
        repeat (10) tick();
        cmp("lowSpaceNoVd", vdCyc, 0);
        cmp("lowSpaceBusy", oDmaBusy, 1);
        iFifoFree = 11'd16;
        tick();
        cmp("spaceIssue", oMUfiVd, 1);
        cmp("spaceAdrs", oMUfiAdrs, 32'h800);
        iFifoFree = 11'd1023;
        iDmaEn = 1'b0;
        repeat (20) tick();
        cmp("throttleIdle", oDmaBusy, 0);
        cmp("throttleAllRet", fifoQ.size(), adrsQ.size());

        // loop with 19-bit address wrap, start latency, reload latency
        clearMon();
        iDmaAdrs = 19'h7FFFE; iDmaLen = 19'd4; iDmaLoop = 1'b1; iDmaEn = 1'b1;
        tick();
        cmp("startBusy", oDmaBusy, 1);
        cmp("startVdLow", oMUfiVd, 0);
        tick();
        cmp("startVdHigh", oMUfiVd, 1);
        cmp("startAdrs", oMUfiAdrs, 32'h7FFFE);
        for (int c = 0; c < 200 && doneCnt < 1; c++) tick();
        cmp("reloadVd", oMUfiVd, 1);
        cmp("reloadAdrs", oMUfiAdrs, 32'h7FFFE);
        for (int c = 0; c < 200 && doneCnt < 2; c++) tick();
        cmp("loopBeats", adrsQ.size(), 8);
        for (int i = 0; i < 8; i++) begin
            ea = 19'h7FFFE + 19'(i % 4);
            if (i < adrsQ.size()) cmp("loopAdrs", adrsQ[i], ea);
        end
        iDmaEn = 1'b0; iDmaLoop = 1'b0;
        repeat (20) tick();
        cmp("loopDonePerPass", doneCnt, 2);
        cmp("loopIdle", oDmaBusy, 0);

        // disable after 3 accepted beats
        clearMon();
        chkGap = 1'b0;
        rdyMode = 2; iMUfiRdy = 1'b1;
        iDmaAdrs = 19'h00400; iDmaLen = 19'd40; iDmaEn = 1'b1;
        for (int c = 0; c < 50 && adrsQ.size() < 3; c++) tick();
        iDmaEn = 1'b0; iMUfiRdy = 1'b0;
        repeat (15) tick();
        cmp("abortBeats", adrsQ.size(), 3);
        cmp("abortWrites", fifoQ.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < fifoQ.size()) cmp("abortData", fifoQ[i], memData(19'h00400 + 19'(i)));
        cmp("abortNoDone", doneCnt, 0);
        cmp("abortIdle", oDmaBusy, 0);

        // zero length: immediate done, then held without retrigger
        iDmaLen = 19'd0; iDmaEn = 1'b1;
        repeat (3) tick();
        cmp("zeroLenDone", doneCnt, 1);
        cmp("zeroLenBusy", oDmaBusy, 0);
        cmp("zeroLenNoBeat", adrsQ.size(), 3);
        repeat (5) tick();
        cmp("holdNoRetrigger", doneCnt, 1);
        iDmaEn = 1'b0;
        repeat (2) tick();

        // reset with two reads in flight
        clearMon();
        iMUfiRdy = 1'b1;
        iDmaAdrs = 19'h00500; iDmaLen = 19'd40; iDmaEn = 1'b1;
        for (int c = 0; c < 50 && adrsQ.size() < 2; c++) tick();
        iSysRst = 1'b1; iMUfiRdy = 1'b0;
        tick();
        cmp("midRstVd", oMUfiVd, 0);
        cmp("midRstREd", oMUfiREd, 0);
        cmp("midRstAdrs", oMUfiAdrs, 0);
        cmp("midRstFifoWe", oFifoWe, 0);
        cmp("midRstBusy", oDmaBusy, 0);
        iSysRst = 1'b0; iDmaEn = 1'b0;
        repeat (10) tick();
        cmp("midRstBeats", adrsQ.size(), 2);
        cmp("lateReturnDropped", fifoQ.size(), 0);
        cmp("midRstNoDone", doneCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
